// File: rtl/shift_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | shift_unit_if                                                        |
// | Request/response bundle between the execute stage and shift_unit.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface shift_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shamt;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;

    modport master (output start, op, din, shamt, input busy, done, dout);
    modport slave  (input start, op, din, shamt, output busy, done, dout);
endinterface
`default_nettype wire

// File: rtl/shift_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | shift_unit                                                           |
// | Iterative SLL/SRL/SRA/ROR shifter, STEP bits per cycle.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int STEP  = 1
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    shift_unit_if.slave  bus
);

    localparam logic [1:0] c_op_sll = 2'b00;
    localparam logic [1:0] c_op_srl = 2'b01;
    localparam logic [1:0] c_op_sra = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [WIDTH-1:0] r_acc, w_acc_nx;
    logic [SHW-1:0]   r_rem, w_rem_nx;
    logic [1:0]       r_mode, w_mode_nx;
    logic             r_sign, w_sign_nx;
    logic [WIDTH-1:0] r_dout, w_dout_nx;

    logic [SHW-1:0]   w_amt;
    logic [SHW:0]     w_ramt;
    logic [WIDTH-1:0] w_srl;
    logic [WIDTH-1:0] w_shifted;

    // rem never exceeds WIDTH-1, so the clamped amount always fits in SHW bits
    assign w_amt  = (int'(r_rem) < STEP) ? r_rem : SHW'(STEP);
    assign w_ramt = (SHW+1)'(WIDTH) - {1'b0, w_amt};
    assign w_srl  = r_acc >> w_amt;

    always_comb begin
        w_shifted = w_srl | (r_acc << w_ramt);
        case (r_mode)
            c_op_sll: w_shifted = r_acc << w_amt;
            c_op_srl: w_shifted = w_srl;
            c_op_sra: w_shifted = w_srl | (~({WIDTH{1'b1}} >> w_amt) & {WIDTH{r_sign}});
            default:  w_shifted = w_srl | (r_acc << w_ramt);
        endcase
    end

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_rem_nx   = r_rem;
        w_mode_nx  = r_mode;
        w_sign_nx  = r_sign;
        w_dout_nx  = r_dout;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (bus.start) begin
                    w_acc_nx   = bus.din;
                    w_rem_nx   = bus.shamt;
                    w_mode_nx  = bus.op;
                    w_sign_nx  = bus.din[WIDTH-1];
                    w_state_nx = ST_SHIFT;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (r_rem != '0) begin
                    w_acc_nx = w_shifted;
                    w_rem_nx = r_rem - w_amt;
                end else begin
                    w_dout_nx  = r_acc;
                    w_state_nx = ST_FIN;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_mode  <= '0;
            r_sign  <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_acc   <= w_acc_nx;
            r_rem   <= w_rem_nx;
            r_mode  <= w_mode_nx;
            r_sign  <= w_sign_nx;
            r_dout  <= w_dout_nx;
        end
    end

    assign bus.busy = (r_state == ST_SHIFT);
    assign bus.done = (r_state == ST_FIN);
    assign bus.dout = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_shift_unit.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_shift_unit                                                        |
// | Random + directed bench for STEP=1 and STEP=4 instances side by side.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_shift_unit;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] din;
    logic [4:0]  shamt;

    always #5 clk = ~clk;

    shift_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) if1 ();
    shift_unit_if #(.WIDTH(WIDTH), .SHW(SHW)) if4 ();

    assign if1.start = start;
    assign if1.op    = op;
    assign if1.din   = din;
    assign if1.shamt = shamt;
    assign if4.start = start;
    assign if4.op    = op;
    assign if4.din   = din;
    assign if4.shamt = shamt;

    shift_unit #(.WIDTH(WIDTH), .SHW(SHW), .STEP(1)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
    shift_unit #(.WIDTH(WIDTH), .SHW(SHW), .STEP(4)) dut4 (.clk(clk), .rstn(rstn), .bus(if4));

    logic        busy_v [2];
    logic        done_v [2];
    logic [31:0] dout_v [2];
    logic [31:0] last_res [2];

    assign busy_v[0] = if1.busy;
    assign busy_v[1] = if4.busy;
    assign done_v[0] = if1.done;
    assign done_v[1] = if4.done;
    assign dout_v[0] = if1.dout;
    assign dout_v[1] = if4.dout;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // Whole-amount shift straight from the mode definitions
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d, input int sh);
        logic [31:0] r;
        case (o)
            2'b00:   r = d << sh;
            2'b01:   r = d >> sh;
            2'b10:   r = 32'($signed(d) >>> sh);
            default: r = (sh == 0) ? d : ((d >> sh) | (d << (32 - sh)));
        endcase
        return r;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s, input bit poke);
        logic [31:0] exp;
        int          n [2];
        bit          fin [2];
        exp = ref_shift(o, d, int'(s));
        for (int k = 0; k < 2; k++) begin
            n[k]   = (int'(s) + step_of(k) - 1) / step_of(k);
            fin[k] = 1'b0;
        end
        @(negedge clk);
        start = 1'b1; op = o; din = d; shamt = s;
        @(posedge clk);
        #1;
        start = 1'b0; din = $urandom; op = 2'($urandom); shamt = 5'($urandom);
        for (int cyc = 1; cyc <= 40 && !(fin[0] && fin[1]); cyc++) begin
            @(posedge clk);
            #1;
            if (poke) begin
                start = (cyc == 2);
                if (cyc == 2) din = ~d;
            end
            for (int k = 0; k < 2; k++) begin
                if (!fin[k]) begin
                    check_value($sformatf("excl_s%0d", step_of(k)), 32'(busy_v[k] & done_v[k]), 32'd0);
                    if (done_v[k]) begin
                        check_value($sformatf("latency_s%0d", step_of(k)), 32'(cyc), 32'(n[k] + 1));
                        check_value($sformatf("result_s%0d_op%0d_sh%0d", step_of(k), o, s), dout_v[k], exp);
                        last_res[k] = exp;
                        fin[k] = 1'b1;
                    end else begin
                        check_value($sformatf("busy_s%0d", step_of(k)), 32'(busy_v[k]), 32'd1);
                        check_value($sformatf("hold_s%0d", step_of(k)), dout_v[k], last_res[k]);
                    end
                end
            end
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++)
            if (!fin[k]) check_value($sformatf("timeout_s%0d", step_of(k)), 32'(fin[k]), 32'd1);
    endtask

    task automatic run_held(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        logic [31:0] exp;
        int          n [2];
        int          cnt [2];
        int          lastc [2];
        exp = ref_shift(o, d, int'(s));
        for (int k = 0; k < 2; k++) begin
            n[k] = (int'(s) + step_of(k) - 1) / step_of(k);
            cnt[k] = 0;
            lastc[k] = 0;
        end
        @(negedge clk);
        start = 1'b1; op = o; din = d; shamt = s;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                if (done_v[k]) begin
                    check_value($sformatf("held_result_s%0d", step_of(k)), dout_v[k], exp);
                    if (start) begin
                        if (cnt[k] > 0)
                            check_value($sformatf("period_s%0d", step_of(k)), 32'(cyc - lastc[k]), 32'(n[k] + 2));
                        lastc[k] = cyc;
                        cnt[k]++;
                    end
                end
            end
            if (start && cnt[0] >= 4 && cnt[1] >= 4) start = 1'b0;
            if (!start && !busy_v[0] && !done_v[0] && !busy_v[1] && !done_v[1]) break;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check_value($sformatf("held_count_s%0d", step_of(k)), 32'(cnt[k] >= 4), 32'd1);
            last_res[k] = exp;
        end
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; op = 2'b00; din = '0; shamt = '0;
        last_res[0] = '0; last_res[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_value("reset_busy", 32'(busy_v[k]), 32'd0);
            check_value("reset_done", 32'(done_v[k]), 32'd0);
            check_value("reset_dout", dout_v[k], 32'd0);
        end
        @(negedge clk);
        rstn = 1'b1;

        run_op(2'b00, 32'h0000_0001, 5'd31, 1'b0);
        run_op(2'b10, 32'h8000_0000, 5'd4,  1'b0);
        run_op(2'b01, 32'h8000_0000, 5'd4,  1'b0);
        run_op(2'b11, 32'h1234_5678, 5'd8,  1'b0);
        run_op(2'b11, 32'h1234_5678, 5'd6,  1'b0);
        for (int o = 0; o < 4; o++)
            run_op(2'(o), 32'hDEAD_BEEF, 5'd0, 1'b0);
        run_op(2'b01, 32'hA5C3_0F96, 5'd20, 1'b1);
        run_op(2'b10, 32'h9000_00F1, 5'd17, 1'b1);
        run_held(2'b10, 32'h8000_0F00, 5'd5);
        run_held(2'b11, 32'hCAFE_0001, 5'd0);
        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), $urandom, 5'($urandom), 1'($urandom_range(0, 3) == 0) && 1'b0);

        // Reset in the middle of a long operation
        run_op(2'b00, 32'h0000_00FF, 5'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b00; din = 32'h0000_0001; shamt = 5'd31;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_value("midrst_busy", 32'(busy_v[k]), 32'd0);
            check_value("midrst_done", 32'(done_v[k]), 32'd0);
            check_value("midrst_dout", dout_v[k], 32'd0);
            last_res[k] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                check_value("no_done_after_rst", 32'(done_v[k]), 32'd0);
        end
        run_op(2'b11, 32'h8765_4321, 5'd13, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
